wm8731_cfg_sched: RTL and testbench

Runtime configuration scheduler for the WM8731 codec control port. After reset it replays a fixed boot table of codec register writes, then arbitrates round-robin among NREQ requesters (volume, mute, sample-rate, effect blocks) for single-register writes. Each write is issued to the shared I2C controller over a GO/END/ACK handshake, with bounded retry and timeout. It sits between the effect/UI logic and the I2C controller, replacing a boot-only configuration sequencer.

---
 rtl/wm8731_cfg_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_wm8731_cfg_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_cfg_sched.sv
// WM8731 control-port scheduler: replays the codec boot table after reset, then
// serves round-robin single-register writes through the shared I2C controller.
module wm8731_cfg_sched #(
  parameter int         NREQ        = 4,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_TRY     = 3,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         BOOT_LEN    = 9
) (
  input  logic              iCLK_50,
  input  logic              iRST_N,
  input  logic [NREQ-1:0]   iReq,
  input  logic [7*NREQ-1:0] iReqAddr,
  input  logic [9*NREQ-1:0] iReqData,
  output logic [NREQ-1:0]   oGrant,
  output logic [NREQ-1:0]   oDone,
  output logic              oErr,
  output logic              oBootDone,
  output logic              oBootErr,
  output logic              oBusy,
  output logic [23:0]       oI2C_DATA,
  output logic              oI2C_GO,
  input  logic              iI2C_END,
  input  logic              iI2C_ACK
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TW = $clog2(MAX_TRY + 1);
  localparam int BW = $clog2(BOOT_LEN + 1);

  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TRY_LAST  = TW'(MAX_TRY);
  localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_LEN - 1);
  localparam logic [BW-1:0]   BOOT_END  = BW'(BOOT_LEN);
  localparam logic [IW-1:0]   PTR_LAST  = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_END = 3'd2,
    S_RELEASE  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   boot_idx_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   cur_idx_r;
  logic [TW-1:0]   try_r;
  logic [CW-1:0]   cnt_r;
  logic            fail_r;
  logic            from_boot_r;
  logic            end_meta_r;
  logic            end_sync_r;
  logic            ack_meta_r;
  logic            ack_sync_r;

  logic            boot_pending_s;
  logic            pick_vld_s;
  logic [IW-1:0]   pick_s;
  int              pick_i_s;
  int              cand_s;
  logic [15:0]     pick_word_s;

  // {register address, register data} for each boot table entry
  function automatic logic [15:0] boot_entry(input logic [BW-1:0] idx);
    logic [15:0] e;
    case (idx)
      BW'(0):  e = {7'd15, 9'h000};
      BW'(1):  e = {7'd0,  9'h018};
      BW'(2):  e = {7'd1,  9'h018};
      BW'(3):  e = {7'd4,  9'h012};
      BW'(4):  e = {7'd5,  9'h007};
      BW'(5):  e = {7'd6,  9'h002};
      BW'(6):  e = {7'd7,  9'h040};
      BW'(7):  e = {7'd8,  9'h000};
      BW'(8):  e = {7'd9,  9'h001};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  assign boot_pending_s = (boot_idx_r < BOOT_END);
  assign pick_word_s    = {iReqAddr[pick_i_s*7 +: 7], iReqData[pick_i_s*9 +: 9]};

  // round-robin search: first asserted request at or after the pointer, wrapping
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = '0;
    pick_i_s   = 0;
    cand_s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_vld_s && iReq[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = IW'(cand_s);
        pick_i_s   = cand_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // END/ACK arrive from the slow I2C clock domain
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      end_meta_r <= 1'b0;
      end_sync_r <= 1'b0;
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
    end else begin
      end_meta_r <= iI2C_END;
      end_sync_r <= end_meta_r;
      ack_meta_r <= iI2C_ACK;
      ack_sync_r <= ack_meta_r;
    end
  end

  // transfer sequencing, retry/timeout handling and all registered outputs
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r     <= S_IDLE;
      boot_idx_r  <= '0;
      rr_ptr_r    <= '0;
      cur_idx_r   <= '0;
      try_r       <= '0;
      cnt_r       <= '0;
      fail_r      <= 1'b0;
      from_boot_r <= 1'b0;
      oGrant      <= '0;
      oDone       <= '0;
      oErr        <= 1'b0;
      oBootDone   <= 1'b0;
      oBootErr    <= 1'b0;
      oBusy       <= 1'b0;
      oI2C_DATA   <= 24'h000000;
      oI2C_GO     <= 1'b0;
    end else begin
      oGrant <= '0;
      oDone  <= '0;
      oErr   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (boot_pending_s) begin
            oI2C_DATA   <= {DEV_ADDR, boot_entry(boot_idx_r)};
            from_boot_r <= 1'b1;
            try_r       <= TW'(1);
            oBusy       <= 1'b1;
            state_r     <= S_ISSUE;
          end else if (pick_vld_s) begin
            oI2C_DATA   <= {DEV_ADDR, pick_word_s};
            from_boot_r <= 1'b0;
            cur_idx_r   <= pick_s;
            oGrant      <= ONE_HOT0 << pick_s;
            rr_ptr_r    <= (pick_s == PTR_LAST) ? '0 : pick_s + IW'(1);
            try_r       <= TW'(1);
            oBusy       <= 1'b1;
            state_r     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          oI2C_GO <= 1'b1;
          cnt_r   <= '0;
          state_r <= S_WAIT_END;
        end
        S_WAIT_END: begin
          if (end_sync_r) begin
            oI2C_GO <= 1'b0;
            fail_r  <= ack_sync_r;
            cnt_r   <= '0;
            state_r <= S_RELEASE;
          end else if (cnt_r == CNT_LAST) begin
            oI2C_GO <= 1'b0;
            fail_r  <= 1'b1;
            cnt_r   <= '0;
            state_r <= S_RELEASE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_RELEASE: begin
          // a stuck-high END must not wedge the scheduler, so this wait is bounded too
          if (!end_sync_r || (cnt_r == CNT_LAST)) begin
            if (fail_r && (try_r < TRY_LAST)) begin
              try_r   <= try_r + TW'(1);
              state_r <= S_ISSUE;
            end else begin
              state_r <= S_DONE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_DONE: begin
          if (from_boot_r) begin
            if (fail_r) begin
              oBootErr <= 1'b1;
            end
            if (boot_idx_r == BOOT_LAST) begin
              oBootDone <= 1'b1;
            end
            boot_idx_r <= boot_idx_r + BW'(1);
          end else begin
            oDone <= ONE_HOT0 << cur_idx_r;
            oErr  <= fail_r;
          end
          oBusy   <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          oI2C_GO <= 1'b0;
          oBusy   <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_cfg_sched.sv
// Directed bench for wm8731_cfg_sched: boot replay, round-robin writes, retry,
// timeout and reset in mid-transfer, against a simple I2C controller model.
`timescale 1ns/1ps
module tb_wm8731_cfg_sched;
  localparam int NREQ     = 4;
  localparam int TOUT     = 1000;
  localparam int XFER_CYC = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [35:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        boot_done;
  logic        boot_err;
  logic        busy;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] boot_exp [0:8] = '{24'h341E00, 24'h340018, 24'h340218, 24'h340812,
                                  24'h340A07, 24'h340C02, 24'h340E40, 24'h341000,
                                  24'h341201};
  logic [23:0] req_exp  [0:3] = '{24'h340655, 24'h340E4A, 24'h340479, 24'h341200};

  always #10 clk = ~clk;

  wm8731_cfg_sched #(
    .NREQ(NREQ), .DEV_ADDR(8'h34), .MAX_TRY(3), .TIMEOUT_CYC(TOUT), .BOOT_LEN(9)
  ) dut (
    .iCLK_50(clk), .iRST_N(rst_n), .iReq(req), .iReqAddr(req_addr), .iReqData(req_data),
    .oGrant(grant), .oDone(done), .oErr(err), .oBootDone(boot_done), .oBootErr(boot_err),
    .oBusy(busy), .oI2C_DATA(i2c_data), .oI2C_GO(i2c_go), .iI2C_END(i2c_end), .iI2C_ACK(i2c_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C controller model: END after XFER_CYC cycles, NAK while m_xfers < nak_target
  int cyc = 0;
  int m_cnt = 0;
  int m_xfers = 0;
  int nak_target = 0;
  int end_rise_cyc = 0;
  bit m_busy = 1'b0;
  bit silent = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      i2c_end <= 1'b0;
      i2c_ack <= 1'b0;
    end else if (!m_busy) begin
      if (i2c_go && !silent) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end
    end else if (!i2c_end) begin
      if (m_cnt >= XFER_CYC) begin
        i2c_end      <= 1'b1;
        i2c_ack      <= (m_xfers < nak_target);
        m_xfers      <= m_xfers + 1;
        end_rise_cyc <= cyc + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (!i2c_go) begin
      i2c_end <= 1'b0;
      i2c_ack <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // event log: GO rising edges with their data word, grants, and done/err pairs
  logic [23:0] go_q[$];
  int grant_q[$];
  int done_q[$];
  logic go_prev = 1'b0;
  int go_start = 0;
  int go_len = 0;
  int go_fall_cyc = 0;

  always @(negedge clk) begin
    if (i2c_go && !go_prev) begin
      go_q.push_back(i2c_data);
      go_start = cyc;
    end
    if (!i2c_go && go_prev) begin
      go_len      = cyc - go_start;
      go_fall_cyc = cyc;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_q.push_back(i);
      if (done[i])  done_q.push_back(i * 2 + int'(err));
    end
    go_prev = i2c_go;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_one(input int idx, output int n_go, output int n_done);
    int go0;
    int d0;
    go0 = go_q.size();
    d0  = done_q.size();
    req[idx] = 1'b1;
    for (int c = 0; c < 10000 && done_q.size() == d0; c++) begin
      tick();
      req = req & ~grant;
    end
    n_go   = go_q.size() - go0;
    n_done = done_q.size() - d0;
  endtask

  function automatic int last_done();
    return (done_q.size() > 0) ? done_q[done_q.size()-1] : -1;
  endfunction

  initial begin
    int seen_bd;
    int grants_at_bd;
    int go_at_bd;
    int n_go;
    int n_done;
    int d0;
    int g0;
    int g1;

    req      = 4'h0;
    req_addr = {7'd9, 7'd2, 7'd7, 7'd3};
    req_data = {9'h000, 9'h079, 9'h04A, 9'h055};
    rst_n    = 1'b1;
    #3;
    rst_n    = 1'b0;
    repeat (3) tick();

    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_boot_done", 32'(boot_done), 32'h0);
    check_eq("rst_boot_err", 32'(boot_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_go", 32'(i2c_go), 32'h0);
    check_eq("rst_data", 32'(i2c_data), 32'h0);

    // all four requesters assert during boot; none may be granted until boot finishes
    req   = 4'hF;
    rst_n = 1'b1;
    seen_bd      = 0;
    grants_at_bd = -1;
    go_at_bd     = -1;
    for (int c = 0; c < 20000 && !(seen_bd == 1 && done_q.size() >= 4); c++) begin
      tick();
      req = req & ~grant;
      if (boot_done && seen_bd == 0) begin
        seen_bd      = 1;
        grants_at_bd = grant_q.size();
        go_at_bd     = go_q.size();
      end
    end
    check_eq("boot_done_seen", 32'(seen_bd), 32'd1);
    check_eq("boot_no_grant", 32'(grants_at_bd), 32'd0);
    check_eq("boot_go_count", 32'(go_at_bd), 32'd9);
    check_eq("boot_err", 32'(boot_err), 32'h0);
    check_eq("rr_go_count", 32'(go_q.size()), 32'd13);
    for (int i = 0; i < 9 && i < go_q.size(); i++)
      check_eq($sformatf("boot_data%0d", i), 32'(go_q[i]), 32'(boot_exp[i]));
    for (int i = 0; i < 4 && 9 + i < go_q.size(); i++)
      check_eq($sformatf("rr_data%0d", i), 32'(go_q[9+i]), 32'(req_exp[i]));
    check_eq("rr_grant_count", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check_eq($sformatf("rr_grant%0d", i), 32'(grant_q[i]), 32'(i));
    for (int i = 0; i < 4 && i < done_q.size(); i++)
      check_eq($sformatf("rr_done%0d", i), 32'(done_q[i]), 32'(i * 2));
    check_eq("end_to_go_fall", 32'(go_fall_cyc - end_rise_cyc), 32'd3);
    tick();
    check_eq("idle_busy", 32'(busy), 32'h0);

    // requester 2, NAK on every attempt
    nak_target = m_xfers + 100;
    run_one(2, n_go, n_done);
    check_eq("nak3_done_seen", 32'(n_done), 32'd1);
    check_eq("nak3_go_pulses", 32'(n_go), 32'd3);
    check_eq("nak3_done_err", 32'(last_done()), 32'd5);
    check_eq("nak3_data", 32'(go_q[go_q.size()-1]), 32'h340479);

    // requester 1, one NAK then ACK
    nak_target = m_xfers + 1;
    tick();
    run_one(1, n_go, n_done);
    check_eq("nak1_done_seen", 32'(n_done), 32'd1);
    check_eq("nak1_go_pulses", 32'(n_go), 32'd2);
    check_eq("nak1_done_err", 32'(last_done()), 32'd2);

    // requester 3, END never arrives
    silent = 1'b1;
    tick();
    run_one(3, n_go, n_done);
    check_eq("tout_done_seen", 32'(n_done), 32'd1);
    check_eq("tout_go_pulses", 32'(n_go), 32'd3);
    check_eq("tout_done_err", 32'(last_done()), 32'd7);
    check_eq("tout_go_len", 32'(go_len), 32'(TOUT));
    silent = 1'b0;

    // reset while boot entry 4 is waiting for END
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = done_q.size();
    g0 = go_q.size();
    for (int c = 0; c < 10000 && go_q.size() < g0 + 5; c++) tick();
    repeat (100) tick();
    check_eq("mid_go_high", 32'(i2c_go), 32'd1);
    check_eq("mid_entry4_data", 32'(go_q[go_q.size()-1]), 32'h340A07);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_go", 32'(i2c_go), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_data", 32'(i2c_data), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    g1 = go_q.size();
    for (int c = 0; c < 100 && go_q.size() == g1; c++) tick();
    check_eq("restart_go_seen", 32'(go_q.size() - g1), 32'd1);
    if (go_q.size() > g1) check_eq("restart_data", 32'(go_q[g1]), 32'h341E00);
    for (int c = 0; c < 20000 && !boot_done; c++) tick();
    check_eq("reboot_done", 32'(boot_done), 32'd1);
    check_eq("reboot_err", 32'(boot_err), 32'd0);
    check_eq("reboot_go_count", 32'(go_q.size() - g1), 32'd9);
    check_eq("no_stale_done", 32'(done_q.size() - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
